// File: rtl/adc_spi_cfg_seq.sv
// SPI configuration sequencer for the two octal ADCs: takes 24-bit instruction
// words over valid/ready and shifts them MSB-first on sclk/sdata with csb1/csb2.
module adc_spi_cfg_seq #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_sel,
  input  logic [23:0] cfg_word,
  input  logic        abort,
  output logic        sclk,
  output logic        sdata,
  output logic        csb1,
  output logic        csb2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_cnt
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] SCLK_HIGH  = CW'(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [22:0]   shreg_q, shreg_d;
  logic          aborted_q, aborted_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic          csb1_q, csb1_d;
  logic          csb2_q, csb2_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic          abort_hit;

  assign abort_hit = abort && ((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    aborted_d  = aborted_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    csb1_d     = csb1_q;
    csb2_d     = csb2_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    word_cnt_d = word_cnt_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_sel == 2'b00) begin
            err_d = 1'b1;
          end else begin
            // sdata_q carries the current bit; shreg_q holds the bits still to go
            state_d   = SETUP;
            cnt_d     = '0;
            bit_d     = 5'd0;
            shreg_d   = cfg_word[22:0];
            sdata_d   = cfg_word[23];
            sclk_d    = 1'b0;
            aborted_d = 1'b0;
            csb1_d    = ~cfg_sel[0];
            csb2_d    = ~cfg_sel[1];
            ready_d   = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd23) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 5'd1;
            sdata_d = shreg_q[22];
            shreg_d = {shreg_q[21:0], 1'b0};
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sclk_d = (cnt_d >= SCLK_HIGH);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          csb1_d  = 1'b1;
          csb2_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          if (!aborted_q) begin
            done_d     = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including the SHIFT->HOLD step in the same cycle
    if (abort_hit) begin
      state_d   = GAP;
      cnt_d     = '0;
      sclk_d    = 1'b0;
      sdata_d   = 1'b0;
      csb1_d    = 1'b1;
      csb2_d    = 1'b1;
      err_d     = 1'b1;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 5'd0;
      shreg_q    <= '0;
      aborted_q  <= 1'b0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      csb1_q     <= 1'b1;
      csb2_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      aborted_q  <= aborted_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      csb1_q     <= csb1_d;
      csb2_q     <= csb2_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign sdata     = sdata_q;
  assign csb1      = csb1_q;
  assign csb2      = csb2_q;
  assign done      = done_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_adc_spi_cfg_seq.sv
// Bench for adc_spi_cfg_seq: records every cycle of each transaction and compares
// the waveform against timing and data expectations derived from the SPI framing rules.
module tb_adc_spi_cfg_seq;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int CSB_LOW  = CS_SETUP + 48 * CLK_DIV + CS_HOLD;
  localparam int DONE_AT  = CSB_LOW + CS_GAP + 1;
  localparam int NREC     = DONE_AT + 10;
  localparam int DEPTH    = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_sel = 2'b00;
  logic [23:0] cfg_word = '0;
  logic        abort = 1'b0;
  logic        sclk, sdata, csb1, csb2, busy, done, err;
  logic [7:0]  word_cnt;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  expWordCnt = 8'd0;
  int          nRec = 0;

  logic sCsb1  [0:DEPTH-1];
  logic sCsb2  [0:DEPTH-1];
  logic sSclk  [0:DEPTH-1];
  logic sSdata [0:DEPTH-1];
  logic sDone  [0:DEPTH-1];
  logic sErr   [0:DEPTH-1];
  logic sReady [0:DEPTH-1];
  logic sBusy  [0:DEPTH-1];

  adc_spi_cfg_seq #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_word (cfg_word),
    .abort    (abort),
    .sclk     (sclk),
    .sdata    (sdata),
    .csb1     (csb1),
    .csb2     (csb2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic sampleCycle(input int i);
    sCsb1[i]  = csb1;
    sCsb2[i]  = csb2;
    sSclk[i]  = sclk;
    sSdata[i] = sdata;
    sDone[i]  = done;
    sErr[i]   = err;
    sReady[i] = cfg_ready;
    sBusy[i]  = busy;
  endtask

  // Cycle 0 is the accept cycle; samples 1..nCyc are taken mid-cycle after it.
  task automatic applyStimulus(input logic [1:0] sel, input logic [23:0] word, input int abortAt,
                               input bit holdValid, input logic [1:0] sel2, input logic [23:0] word2,
                               input int nCyc);
    @(negedge clk);
    sampleCycle(0);
    checkOutput("ready_before_accept", 64'(cfg_ready), 64'(1));
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_word  = word;
    @(posedge clk);
    #1;
    if (holdValid) begin
      cfg_sel  = sel2;
      cfg_word = word2;
    end else begin
      cfg_valid = 1'b0;
    end
    for (int i = 1; i <= nCyc; i++) begin
      @(negedge clk);
      sampleCycle(i);
      if (holdValid && cfg_valid && sDone[i]) begin
        @(posedge clk);
        #1 cfg_valid = 1'b0;
      end
      if (i == abortAt) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
    end
    nRec = nCyc;
  endtask

  function automatic int lowCount(input bit second);
    int n = 0;
    for (int i = 1; i <= nRec; i++) if ((second ? sCsb2[i] : sCsb1[i]) == 1'b0) n++;
    return n;
  endfunction

  function automatic int firstLow(input bit second);
    for (int i = 1; i <= nRec; i++) if ((second ? sCsb2[i] : sCsb1[i]) == 1'b0) return i;
    return -1;
  endfunction

  function automatic int lastLow(input bit second);
    int l = -1;
    for (int i = 1; i <= nRec; i++) if ((second ? sCsb2[i] : sCsb1[i]) == 1'b0) l = i;
    return l;
  endfunction

  function automatic int pulseCount(input bit isErr);
    int n = 0;
    for (int i = 1; i <= nRec; i++) if (isErr ? sErr[i] : sDone[i]) n++;
    return n;
  endfunction

  function automatic int firstPulse(input bit isErr);
    for (int i = 1; i <= nRec; i++) if (isErr ? sErr[i] : sDone[i]) return i;
    return -1;
  endfunction

  function automatic int riseCount();
    int n = 0;
    for (int i = 1; i <= nRec; i++) if (sSclk[i] && !sSclk[i-1]) n++;
    return n;
  endfunction

  // Bits as an ADC would see them: sdata just before each sclk rising edge.
  function automatic logic [47:0] captured();
    logic [47:0] c;
    c = '0;
    for (int i = 1; i <= nRec; i++) if (sSclk[i] && !sSclk[i-1]) c = {c[46:0], sSdata[i-1]};
    return c;
  endfunction

  function automatic int sdataViol();
    int n = 0;
    for (int i = 1; i <= nRec; i++) if ((sSdata[i] !== sSdata[i-1]) && sSclk[i]) n++;
    return n;
  endfunction

  function automatic int csbDiff();
    int n = 0;
    for (int i = 0; i <= nRec; i++) if (sCsb1[i] !== sCsb2[i]) n++;
    return n;
  endfunction

  function automatic int readyLowCount();
    int n = 0;
    for (int i = 0; i <= nRec; i++) if (!sReady[i]) n++;
    return n;
  endfunction

  task automatic checkNormal(input string tag, input logic [1:0] sel, input logic [23:0] word);
    logic [47:0] cap;
    cap = captured();
    checkOutput({tag, "_csb1_low"}, 64'(lowCount(1'b0)), 64'(sel[0] ? CSB_LOW : 0));
    checkOutput({tag, "_csb2_low"}, 64'(lowCount(1'b1)), 64'(sel[1] ? CSB_LOW : 0));
    checkOutput({tag, "_csb_first_low"}, 64'(firstLow(!sel[0])), 64'(1));
    checkOutput({tag, "_sclk_rises"}, 64'(riseCount()), 64'(24));
    checkOutput({tag, "_data"}, 64'(cap[23:0]), 64'(word));
    checkOutput({tag, "_done_count"}, 64'(pulseCount(1'b0)), 64'(1));
    checkOutput({tag, "_done_cycle"}, 64'(firstPulse(1'b0)), 64'(DONE_AT));
    checkOutput({tag, "_err_count"}, 64'(pulseCount(1'b1)), 64'(0));
    checkOutput({tag, "_sdata_while_high"}, 64'(sdataViol()), 64'(0));
    checkOutput({tag, "_ready_busy"}, 64'({sReady[DONE_AT-1], sReady[DONE_AT], sBusy[1], sBusy[DONE_AT]}), 64'(4'b0110));
    if (sel == 2'b11) checkOutput({tag, "_bcast_identical"}, 64'(csbDiff()), 64'(0));
    expWordCnt = expWordCnt + 8'd1;
    checkOutput({tag, "_word_cnt"}, 64'(word_cnt), 64'(expWordCnt));
  endtask

  task automatic checkAbort(input string tag, input logic [1:0] sel, input int a);
    checkOutput({tag, "_csb_low_until_abort"}, 64'(lowCount(!sel[0])), 64'(a));
    checkOutput({tag, "_after_abort"}, 64'({sCsb1[a+1], sCsb2[a+1], sSclk[a+1], sSdata[a+1]}), 64'(4'b1100));
    checkOutput({tag, "_err_count"}, 64'(pulseCount(1'b1)), 64'(1));
    checkOutput({tag, "_err_cycle"}, 64'(firstPulse(1'b1)), 64'(a + 1));
    checkOutput({tag, "_done_count"}, 64'(pulseCount(1'b0)), 64'(0));
    checkOutput({tag, "_ready_after_gap"}, 64'({sReady[a+CS_GAP], sReady[a+CS_GAP+1]}), 64'(2'b01));
    checkOutput({tag, "_sdata_while_high"}, 64'(sdataViol()), 64'(0));
    checkOutput({tag, "_word_cnt"}, 64'(word_cnt), 64'(expWordCnt));
  endtask

  initial begin
    logic [1:0]  sel;
    logic [23:0] w1, w2;
    logic [47:0] cap;
    int          a;

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 64'({csb1, csb2, sclk, sdata, cfg_ready, busy, done, err, word_cnt}), 64'(16'hC800));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(2'b01, 24'h000800, 0, 1'b0, 2'b00, '0, NREC);
    checkNormal("soft_reset", 2'b01, 24'h000800);

    applyStimulus(2'b11, 24'h001403, 0, 1'b0, 2'b00, '0, NREC);
    checkNormal("broadcast", 2'b11, 24'h001403);

    applyStimulus(2'b00, 24'h123456, 0, 1'b0, 2'b00, '0, 12);
    checkOutput("sel00_err_count", 64'(pulseCount(1'b1)), 64'(1));
    checkOutput("sel00_err_cycle", 64'(firstPulse(1'b1)), 64'(1));
    checkOutput("sel00_csb_activity", 64'(lowCount(1'b0) + lowCount(1'b1) + riseCount()), 64'(0));
    checkOutput("sel00_ready_low", 64'(readyLowCount()), 64'(0));
    checkOutput("sel00_word_cnt", 64'(word_cnt), 64'(expWordCnt));

    w1 = 24'($urandom);
    w2 = 24'($urandom);
    applyStimulus(2'b01, w1, 0, 1'b1, 2'b10, w2, 2 * DONE_AT + 10);
    cap = captured();
    checkOutput("b2b_csb1_low", 64'(lowCount(1'b0)), 64'(CSB_LOW));
    checkOutput("b2b_csb1_last_low", 64'(lastLow(1'b0)), 64'(CSB_LOW));
    checkOutput("b2b_csb2_first_low", 64'(firstLow(1'b1)), 64'(DONE_AT + 1));
    checkOutput("b2b_csb2_low", 64'(lowCount(1'b1)), 64'(CSB_LOW));
    checkOutput("b2b_csb_gap_ok", 64'(firstLow(1'b1) - lastLow(1'b0) - 1 >= CS_GAP + 1), 64'(1));
    checkOutput("b2b_done_count", 64'(pulseCount(1'b0)), 64'(2));
    checkOutput("b2b_data", 64'(cap), 64'({w1, w2}));
    checkOutput("b2b_sdata_while_high", 64'(sdataViol()), 64'(0));
    expWordCnt = expWordCnt + 8'd2;
    checkOutput("b2b_word_cnt", 64'(word_cnt), 64'(expWordCnt));

    // Bit 10 (counting from the MSB) occupies SHIFT cycles 10*2*CLK_DIV .. +2*CLK_DIV-1
    a = CS_SETUP + 1 + 10 * 2 * CLK_DIV + $urandom_range(0, 2 * CLK_DIV - 1);
    applyStimulus(2'b01, 24'($urandom), a, 1'b0, 2'b00, '0, NREC);
    checkAbort("abort_bit10", 2'b01, a);

    for (int t = 0; t < 30; t++) begin
      sel = 2'($urandom_range(1, 3));
      w1  = 24'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, CSB_LOW) : 0;
      applyStimulus(sel, w1, a, 1'b0, 2'b00, '0, NREC);
      if (a != 0) checkAbort("rand_abort", sel, a);
      else checkNormal("rand_word", sel, w1);
    end

    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_sel   = 2'b11;
    cfg_word  = 24'($urandom);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("reset_mid_shift", 64'({csb1, csb2, sclk, sdata, cfg_ready, busy, done, err, word_cnt}), 64'(16'hC800));
    @(negedge clk);
    rstn = 1'b1;
    expWordCnt = 8'd0;

    for (int t = 0; t < 256; t++) begin
      sel = 2'($urandom_range(1, 3));
      w1  = 24'($urandom);
      applyStimulus(sel, w1, 0, 1'b0, 2'b00, '0, NREC);
      checkNormal("wrap_word", sel, w1);
    end
    checkOutput("word_cnt_wrapped", 64'(word_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
